// File: rtl/skid_buffer_pkg.sv
// Shared types and constants for the two-entry valid/ready skid buffer.
package skid_buffer_pkg;

  localparam int unsigned STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

endpackage

// File: rtl/dff.sv
// Plain W-bit retiming register with no reset and no enable.
module dff #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk) begin
    o_q <= i_d;
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready never depends combinationally on out_ready.
// Optional stall-cycle counter enabled by defining SKID_BUFFER_STATS_EN.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  input  logic                   out_ready
`ifdef SKID_BUFFER_STATS_EN
  ,
  input  logic                   stall_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_out_load;
  logic         w_out_from_skid;
  logic         w_skid_load;
  logic [W-1:0] w_out_d;
  logic [W-1:0] w_skid_d;
  logic [W-1:0] w_skid_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and payload load controls; the unused code behaves as EMPTY.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_load      = 1'b0;
    w_out_from_skid = 1'b0;
    w_skid_load     = 1'b0;
    case (r_state)
      BUSY: begin
        if (in_valid && out_ready) begin
          w_out_load = 1'b1;
        end else if (in_valid) begin
          w_skid_load = 1'b1;
          w_state_nxt = FULL;
        end else if (out_ready) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          w_out_load      = 1'b1;
          w_out_from_skid = 1'b1;
          w_state_nxt     = BUSY;
        end
      end
      default: begin
        if (in_valid) begin
          w_out_load  = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = EMPTY;
        end
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (r_state)
      BUSY: begin
        out_valid = 1'b1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
    endcase
  end

  // Payload registers recirculate their own value when not loading.
  assign w_out_d  = w_out_load ? (w_out_from_skid ? w_skid_q : in_data) : out_data;
  assign w_skid_d = w_skid_load ? in_data : w_skid_q;

  dff #(.W(W)) u_out_reg (
    .clk (clk),
    .i_d (w_out_d),
    .o_q (out_data)
  );

  dff #(.W(W)) u_skid_reg (
    .clk (clk),
    .i_d (w_skid_d),
    .o_q (w_skid_q)
  );

`ifdef SKID_BUFFER_STATS_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: depth-2 FIFO reference model plus directed literal checks.
module tb_skid_buffer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
`ifdef SKID_BUFFER_STATS_EN
  logic         stall_clr;
  logic [31:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mq[$];

  skid_buffer #(.W(W)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef SKID_BUFFER_STATS_EN
    ,
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of capacity two; ready while not full, valid while not empty.
  always @(posedge clk or negedge arst_n) begin
    bit acc;
    bit take;
    if (!arst_n) begin
      mq.delete();
    end else begin
      acc  = (in_valid === 1'b1) && (mq.size() < 2);
      take = (mq.size() > 0) && (out_ready === 1'b1);
      if (take) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (arst_n === 1'b1) begin
      chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("m_out_data", 64'(out_data), 64'(mq[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  initial begin
    arst_n    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef SKID_BUFFER_STATS_EN
    stall_clr = 1'b0;
`endif
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    #11;
    arst_n = 1'b1;
    step();

    // Streaming 0x1..0x10 with no bubbles
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(W'(i));
      chk("stream_valid", 64'(out_valid), 64'(1));
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", 64'(out_valid), 64'(0));

    // Backpressure: A, B fill the buffer, C is held off
    out_ready = 1'b0;
    send(W'(32'hA));
    chk("bp_a_ready", 64'(in_ready), 64'(1));
    chk("bp_a_data", 64'(out_data), 64'(32'hA));
    send(W'(32'hB));
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    chk("bp_full_valid", 64'(out_valid), 64'(1));
    chk("bp_full_data", 64'(out_data), 64'(32'hA));
    send(W'(32'hC));
    chk("bp_hold_ready", 64'(in_ready), 64'(0));
    chk("bp_hold_data", 64'(out_data), 64'(32'hA));
    out_ready = 1'b1;
    step();
    chk("bp_b_data", 64'(out_data), 64'(32'hB));
    chk("bp_recover_ready", 64'(in_ready), 64'(1));
    step();
    chk("bp_c_data", 64'(out_data), 64'(32'hC));
    in_valid = 1'b0;
    step();
    chk("bp_drained", 64'(out_valid), 64'(0));

    // Simultaneous accept and take in BUSY
    out_ready = 1'b0;
    send(W'(32'h44));
    chk("sim_44", 64'(out_data), 64'(32'h44));
    out_ready = 1'b1;
    send(W'(32'h55));
    chk("sim_55", 64'(out_data), 64'(32'h55));
    chk("sim_busy_valid", 64'(out_valid), 64'(1));
    chk("sim_busy_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    step();

    // Drain of a single beat
    send(W'(32'h7));
    chk("drain_valid", 64'(out_valid), 64'(1));
    chk("drain_data", 64'(out_data), 64'(32'h7));
    in_valid = 1'b0;
    step();
    chk("drain_empty", 64'(out_valid), 64'(0));
    step();
    chk("drain_stay", 64'(out_valid), 64'(0));

`ifdef SKID_BUFFER_STATS_EN
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("stat_clr0", 64'(stall_cnt), 64'(0));
    out_ready = 1'b0;
    send(W'(32'h9));
    in_valid = 1'b0;
    repeat (5) step();
    chk("stat_five", 64'(stall_cnt), 64'(5));
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("stat_clr1", 64'(stall_cnt), 64'(0));
    out_ready = 1'b1;
    step();
    chk("stat_idle", 64'(stall_cnt), 64'(0));
`endif

    // Mixed valid/ready patterns against the model
    for (int i = 0; i < 48; i++) begin
      in_valid  = ((i * 7) % 5) != 0;
      out_ready = ((i * 3) % 7) < 4;
      in_data   = W'(32'h100 + i);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("mix_drained", 64'(out_valid), 64'(0));

    // Reset while FULL
    out_ready = 1'b0;
    send(W'(32'h11));
    send(W'(32'h22));
    chk("rf_full", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    arst_n   = 1'b0;
    #1;
    chk("rf_out_valid", 64'(out_valid), 64'(0));
    chk("rf_in_ready", 64'(in_ready), 64'(1));
`ifdef SKID_BUFFER_STATS_EN
    chk("rf_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    #2;
    arst_n = 1'b1;
    step();
    chk("rf_post_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    send(W'(32'h33));
    chk("rf_new_data", 64'(out_data), 64'(32'h33));
    chk("rf_new_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    step();
    chk("rf_final_empty", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
